// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, ALU op classes, hazard FSM states,
// immediate formats and the decoded control bundle.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_I   = 2'b11;

    typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_t;

    typedef struct packed {
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       regwrite;
        logic       branch;
        logic       alusrc;
        logic [1:0] aluop;
    } ctrl_t;

    function automatic fmt_t opc_fmt(input logic [6:0] opc);
        case (opc)
            OP_REG:                    return FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  return FMT_I;
            OP_STORE:                  return FMT_S;
            OP_BRANCH:                 return FMT_B;
            OP_LUI, OP_AUIPC:          return FMT_U;
            OP_JAL:                    return FMT_J;
            default:                   return FMT_X;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_pipelined_if.sv
// IF->ID handshake and ID/EX register contents toward EX.
interface id_stage_pipelined_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] pc_in;
    logic [31:0]     instr_in;
    logic            ex_ready;

    logic            id_valid;
    logic [XLEN-1:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [2:0]      id_funct3;
    logic [6:0]      id_funct7, id_opcode;
    logic            id_memread, id_memtoreg, id_memwrite, id_regwrite;
    logic            id_branch, id_alusrc, id_illegal;
    logic [1:0]      id_aluop;

    modport slave (
        input  if_valid, pc_in, instr_in, ex_ready,
        output if_ready, id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7, id_opcode,
               id_memread, id_memtoreg, id_memwrite, id_regwrite,
               id_branch, id_alusrc, id_illegal, id_aluop
    );

    modport master (
        output if_valid, pc_in, instr_in, ex_ready,
        input  if_ready, id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7, id_opcode,
               id_memread, id_memtoreg, id_memwrite, id_regwrite,
               id_branch, id_alusrc, id_illegal, id_aluop
    );
endinterface

// File: rtl/id_regfile.sv
// Two-read/one-write register file with x0 hardwired to zero and optional
// same-cycle WB->read bypass. Out-of-range indices write nothing and read zero.
module id_regfile #(
    parameter int REG_COUNT = 32,
    parameter int XLEN      = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);
    localparam int         IW  = $clog2(REG_COUNT);
    localparam logic [5:0] RC6 = 6'(REG_COUNT);

    logic [XLEN-1:0] mem [REG_COUNT];
    logic [4:0]      ra [2];
    logic [XLEN-1:0] rdv [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
        end else if (we && wa != 5'd0 && {1'b0, wa} < RC6) begin
            mem[wa[IW-1:0]] <= wd;
        end
    end

    assign ra[0] = ra1;
    assign ra[1] = ra2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdv[p] = mem[ra[p][IW-1:0]];
            if (BYPASS_EN != 0 && we && wa == ra[p]) rdv[p] = wd;
            if (ra[p] == 5'd0 || {1'b0, ra[p]} >= RC6) rdv[p] = '0;
        end
    end

    assign rd1 = rdv[0];
    assign rd2 = rdv[1];
endmodule

// File: rtl/id_stage_pipelined.sv
// RISC-V decode stage with built-in ID/EX register: decode, regfile read,
// immediate generation and a load-use stall FSM with a programmable bubble count.
module id_stage_pipelined
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_COUNT  = 32,
    parameter int LOAD_DELAY = 1,
    parameter int BYPASS_EN  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    id_stage_pipelined_if.slave  bus,
    input  logic                 wb_we,
    input  logic [4:0]           wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 ex_memread,
    input  logic [4:0]           ex_rd,
    input  logic                 flush
);
    localparam logic [5:0] RC6 = 6'(REG_COUNT);
    localparam int         CW  = (LOAD_DELAY > 1) ? $clog2(LOAD_DELAY) : 1;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc, imm, rs1_data, rs2_data;
        logic [4:0]      rs1, rs2, rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7, opcode;
        ctrl_t           ctrl;
        logic            illegal;
    } idex_t;

    logic [31:0]     instr, imm32;
    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    fmt_t            fmt;
    logic            rs1_used, rs2_used, rd_used, illegal, hazard;
    logic [XLEN-1:0] rs1_data, rs2_data;
    ctrl_t           ctrl;
    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            if_rdy, take, bubble;
    idex_t           idex;

    assign instr  = bus.instr_in;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign fmt    = opc_fmt(opcode);

    assign rs1_used = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    assign rs2_used = fmt inside {FMT_R, FMT_S, FMT_B};
    assign rd_used  = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};

    assign illegal = (fmt == FMT_X)
                   || (rs1_used && {1'b0, rs1} >= RC6)
                   || (rs2_used && {1'b0, rs2} >= RC6)
                   || (rd_used  && {1'b0, rd}  >= RC6);

    id_regfile #(.REG_COUNT(REG_COUNT), .XLEN(XLEN), .BYPASS_EN(BYPASS_EN)) u_rf (
        .clk (clk),
        .rst (rst),
        .we  (wb_we),
        .wa  (wb_rd),
        .wd  (wb_data),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rs1_data),
        .rd2 (rs2_data)
    );

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Jumps are flagged as branches so EX treats them as control transfers.
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_LOAD:   begin ctrl.memread = 1'b1; ctrl.memtoreg = 1'b1; ctrl.regwrite = 1'b1;
                             ctrl.alusrc = 1'b1; ctrl.aluop = ALU_ADD; end
            OP_STORE:  begin ctrl.memwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.aluop = ALU_ADD; end
            OP_BRANCH: begin ctrl.branch = 1'b1; ctrl.aluop = ALU_BR; end
            OP_REG:    begin ctrl.regwrite = 1'b1; ctrl.aluop = ALU_R; end
            OP_IMM:    begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.aluop = ALU_I; end
            OP_LUI, OP_AUIPC:
                       begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.aluop = ALU_ADD; end
            OP_JAL, OP_JALR:
                       begin ctrl.regwrite = 1'b1; ctrl.branch = 1'b1; ctrl.alusrc = 1'b1;
                             ctrl.aluop = ALU_ADD; end
            default:   ctrl = '0;
        endcase
    end

    assign hazard = ex_memread && ex_rd != 5'd0 && bus.if_valid
                 && ((ex_rd == rs1 && rs1_used) || (ex_rd == rs2 && rs2_used));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (flush) begin
            state_n = ST_RUN;
            cnt_n   = '0;
        end else if (bus.ex_ready) begin
            case (state)
                ST_RUN: if (hazard && LOAD_DELAY > 1) begin
                    state_n = ST_STALL;
                    cnt_n   = CW'(LOAD_DELAY - 1);
                end
                ST_STALL: if (cnt == CW'(1)) begin
                    state_n = ST_RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
                default: state_n = ST_RUN;
            endcase
        end
    end

    // Any EX-ready cycle that does not accept an instruction shifts in a bubble.
    always_comb begin
        if_rdy = bus.ex_ready && state == ST_RUN && !hazard && !flush;
        take   = bus.if_valid && if_rdy;
        bubble = flush || (bus.ex_ready && !take);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex <= '0;
        end else if (take) begin
            idex.valid    <= 1'b1;
            idex.pc       <= bus.pc_in;
            idex.imm      <= XLEN'($signed(imm32));
            idex.rs1_data <= rs1_data;
            idex.rs2_data <= rs2_data;
            idex.rs1      <= rs1;
            idex.rs2      <= rs2;
            idex.rd       <= rd;
            idex.funct3   <= instr[14:12];
            idex.funct7   <= instr[31:25];
            idex.opcode   <= opcode;
            idex.ctrl     <= ctrl;
            idex.illegal  <= illegal;
        end else if (bubble) begin
            idex.valid   <= 1'b0;
            idex.ctrl    <= '0;
            idex.illegal <= 1'b0;
        end
    end

    assign bus.if_ready    = if_rdy;
    assign bus.id_valid    = idex.valid;
    assign bus.id_pc       = idex.pc;
    assign bus.id_imm      = idex.imm;
    assign bus.id_rs1_data = idex.rs1_data;
    assign bus.id_rs2_data = idex.rs2_data;
    assign bus.id_rs1      = idex.rs1;
    assign bus.id_rs2      = idex.rs2;
    assign bus.id_rd       = idex.rd;
    assign bus.id_funct3   = idex.funct3;
    assign bus.id_funct7   = idex.funct7;
    assign bus.id_opcode   = idex.opcode;
    assign bus.id_memread  = idex.ctrl.memread;
    assign bus.id_memtoreg = idex.ctrl.memtoreg;
    assign bus.id_memwrite = idex.ctrl.memwrite;
    assign bus.id_regwrite = idex.ctrl.regwrite;
    assign bus.id_branch   = idex.ctrl.branch;
    assign bus.id_alusrc   = idex.ctrl.alusrc;
    assign bus.id_aluop    = idex.ctrl.aluop;
    assign bus.id_illegal  = idex.illegal;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed scoreboard bench: DUT A (RV32I, 2-cycle load delay, bypass) and
// DUT B (RV32E, 1-cycle load delay, no bypass) share stimulus; sel picks the fetch target.
module tb_id_stage_pipelined;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic        v = 1'b0, exr = 1'b1, flush = 1'b0, sel = 1'b0;
    logic [31:0] pcv = '0, ins = '0;
    logic        wwe = 1'b0;
    logic [4:0]  wrd = '0;
    logic [31:0] wdat = '0;
    logic        exm = 1'b0;
    logic [4:0]  exrd = '0;

    id_stage_pipelined_if #(.XLEN(32)) ia ();
    id_stage_pipelined_if #(.XLEN(32)) ib ();

    assign ia.if_valid = v & ~sel;
    assign ib.if_valid = v & sel;
    assign ia.pc_in    = pcv;
    assign ib.pc_in    = pcv;
    assign ia.instr_in = ins;
    assign ib.instr_in = ins;
    assign ia.ex_ready = exr;
    assign ib.ex_ready = exr;

    id_stage_pipelined #(.XLEN(32), .REG_COUNT(32), .LOAD_DELAY(2), .BYPASS_EN(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave), .wb_we(wwe), .wb_rd(wrd), .wb_data(wdat),
        .ex_memread(exm), .ex_rd(exrd), .flush(flush)
    );
    id_stage_pipelined #(.XLEN(32), .REG_COUNT(16), .LOAD_DELAY(1), .BYPASS_EN(0)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave), .wb_we(wwe), .wb_rd(wrd), .wb_data(wdat),
        .ex_memread(exm), .ex_rd(exrd), .flush(flush)
    );

    logic        o_ready, o_valid, o_ill;
    logic [31:0] o_pc, o_imm, o_d1, o_d2;
    logic [1:0]  o_aluop;
    logic [5:0]  o_ctl;
    logic [4:0]  o_rd;

    assign o_ready = sel ? ib.if_ready    : ia.if_ready;
    assign o_valid = sel ? ib.id_valid    : ia.id_valid;
    assign o_ill   = sel ? ib.id_illegal  : ia.id_illegal;
    assign o_pc    = sel ? ib.id_pc       : ia.id_pc;
    assign o_imm   = sel ? ib.id_imm      : ia.id_imm;
    assign o_d1    = sel ? ib.id_rs1_data : ia.id_rs1_data;
    assign o_d2    = sel ? ib.id_rs2_data : ia.id_rs2_data;
    assign o_aluop = sel ? ib.id_aluop    : ia.id_aluop;
    assign o_rd    = sel ? ib.id_rd       : ia.id_rd;
    assign o_ctl   = sel ? {ib.id_memread, ib.id_memtoreg, ib.id_memwrite, ib.id_regwrite,
                            ib.id_branch, ib.id_alusrc}
                         : {ia.id_memread, ia.id_memtoreg, ia.id_memwrite, ia.id_regwrite,
                            ia.id_branch, ia.id_alusrc};

    // ctl order: memread, memtoreg, memwrite, regwrite, branch, alusrc
    typedef struct {
        logic [31:0] pc, imm, d1, d2;
        logic [1:0]  aluop;
        logic [5:0]  ctl;
        logic        ill;
        logic [4:0]  rd;
    } exp_t;

    exp_t  sb[$];
    exp_t  pend;
    int    nvec = 0, nmis = 0;
    string step = "reset";
    logic  seen_v, acc;

    function automatic exp_t mk(input logic [31:0] pc, imm, d1, d2, input logic [1:0] aluop,
                                input logic [5:0] ctl, input logic ill, input logic [4:0] rd);
        exp_t e;
        e.pc = pc; e.imm = imm; e.d1 = d1; e.d2 = d2;
        e.aluop = aluop; e.ctl = ctl; e.ill = ill; e.rd = rd;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
        end
    endtask

    task automatic tick(output logic a);
        exp_t e;
        @(negedge clk);
        seen_v = o_valid;
        if (o_valid) begin
            if (sb.size() == 0) begin
                chk("valid_without_expect", 32'(o_valid), 32'd0);
            end else begin
                e = sb[0];
                chk("pc", o_pc, e.pc);
                chk("imm", o_imm, e.imm);
                chk("rs1_data", o_d1, e.d1);
                chk("rs2_data", o_d2, e.d2);
                chk("aluop", 32'(o_aluop), 32'(e.aluop));
                chk("ctrl", 32'(o_ctl), 32'(e.ctl));
                chk("illegal", 32'(o_ill), 32'(e.ill));
                chk("rd", 32'(o_rd), 32'(e.rd));
                if (exr) void'(sb.pop_front());
            end
        end
        a = v & o_ready;
        if (a) sb.push_back(pend);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] i_ins, i_pc, input exp_t e);
        logic a;
        a = 1'b0;
        ins = i_ins; pcv = i_pc; pend = e; v = 1'b1;
        for (int k = 0; k < 20 && !a; k++) tick(a);
        chk("accept_timeout", 32'(a), 32'd1);
        v = 1'b0;
    endtask

    task automatic wbw(input logic [4:0] r, input logic [31:0] d);
        logic a;
        wwe = 1'b1; wrd = r; wdat = d;
        tick(a);
        wwe = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(ia.id_valid), 32'd0);
        chk("rst_imm", ia.id_imm, 32'd0);
        chk("rst_rs1_data", ia.id_rs1_data, 32'd0);
        chk("rst_ctrl", 32'(o_ctl), 32'd0);
        chk("rst_b_valid", 32'(ib.id_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        step = "setup";
        wbw(5'd5, 32'h1234);
        wbw(5'd1, 32'h11);
        wbw(5'd9, 32'h0BAD);
        wbw(5'd4, 32'h4444);
        wbw(5'd20, 32'h5555);

        step = "T1_add";
        issue({7'h0, 5'd5, 5'd5, 3'd0, 5'd7, 7'h33}, 32'h100,
              mk(32'h100, 32'h0, 32'h1234, 32'h1234, 2'b10, 6'b000100, 1'b0, 5'd7));

        step = "T4_imm";
        issue({7'h7F, 5'd5, 5'd2, 3'b010, 5'h1C, 7'h23}, 32'h104,
              mk(32'h104, 32'hFFFFFFFC, 32'h0, 32'h1234, 2'b00, 6'b001001, 1'b0, 5'h1C));
        issue(32'h001000EF, 32'h108,
              mk(32'h108, 32'h800, 32'h0, 32'h11, 2'b00, 6'b000111, 1'b0, 5'd1));
        issue({12'hFFF, 5'd5, 3'd0, 5'd6, 7'h13}, 32'h10C,
              mk(32'h10C, 32'hFFFFFFFF, 32'h1234, 32'h0, 2'b11, 6'b000101, 1'b0, 5'd6));

        step = "hold";
        exr = 1'b0;
        tick(acc); chk("hold_valid0", 32'(seen_v), 32'd1);
        tick(acc); chk("hold_valid1", 32'(seen_v), 32'd1);
        exr = 1'b1;
        tick(acc);

        step = "T2_loaduse_a";
        exm = 1'b1; exrd = 5'd3;
        ins = {7'h0, 5'd1, 5'd3, 3'd0, 5'd4, 7'h33}; pcv = 32'h110;
        pend = mk(32'h110, 32'h0, 32'h0, 32'h11, 2'b10, 6'b000100, 1'b0, 5'd4);
        v = 1'b1;
        tick(acc); chk("stall0_ready", 32'(acc), 32'd0);
        exm = 1'b0;
        tick(acc); chk("stall1_ready", 32'(acc), 32'd0);
        chk("bubble1", 32'(seen_v), 32'd0);
        tick(acc); chk("resume_ready", 32'(acc), 32'd1);
        chk("bubble2", 32'(seen_v), 32'd0);
        v = 1'b0;
        tick(acc);

        step = "T2_loaduse_b";
        sel = 1'b1;
        exm = 1'b1; exrd = 5'd3;
        ins = {7'h0, 5'd1, 5'd3, 3'd0, 5'd4, 7'h33}; pcv = 32'h200;
        pend = mk(32'h200, 32'h0, 32'h0, 32'h11, 2'b10, 6'b000100, 1'b0, 5'd4);
        v = 1'b1;
        tick(acc); chk("stall0_ready", 32'(acc), 32'd0);
        exm = 1'b0;
        tick(acc); chk("resume_ready", 32'(acc), 32'd1);
        v = 1'b0;

        step = "T3_nobypass_b";
        wwe = 1'b1; wrd = 5'd9; wdat = 32'hDEAD;
        issue({7'h0, 5'd0, 5'd9, 3'd0, 5'd10, 7'h33}, 32'h204,
              mk(32'h204, 32'h0, 32'h0BAD, 32'h0, 2'b10, 6'b000100, 1'b0, 5'd10));
        wwe = 1'b0;
        tick(acc);

        step = "T6_rv32e_b";
        issue({12'h0, 5'd20, 3'd0, 5'd1, 7'h13}, 32'h208,
              mk(32'h208, 32'h0, 32'h0, 32'h0, 2'b11, 6'b000101, 1'b1, 5'd1));
        tick(acc);

        step = "T3_bypass_a";
        sel = 1'b0;
        wwe = 1'b1; wrd = 5'd9; wdat = 32'hBEEF;
        issue({7'h0, 5'd0, 5'd9, 3'd0, 5'd10, 7'h33}, 32'h118,
              mk(32'h118, 32'h0, 32'hBEEF, 32'h0, 2'b10, 6'b000100, 1'b0, 5'd10));
        wwe = 1'b0;

        step = "T6_badop_a";
        issue(32'h0000007F, 32'h120,
              mk(32'h120, 32'h0, 32'h0, 32'h0, 2'b00, 6'b000000, 1'b1, 5'd0));
        tick(acc);

        step = "T5_flush";
        exm = 1'b1; exrd = 5'd3;
        ins = {7'h0, 5'd1, 5'd3, 3'd0, 5'd4, 7'h33}; pcv = 32'h130;
        pend = mk(32'h130, 32'h0, 32'h0, 32'h11, 2'b10, 6'b000100, 1'b0, 5'd4);
        v = 1'b1;
        tick(acc); chk("stall_ready", 32'(acc), 32'd0);
        exm = 1'b0; exr = 1'b0; flush = 1'b1;
        tick(acc); chk("flush_ready", 32'(acc), 32'd0);
        flush = 1'b0;
        tick(acc); chk("exr0_ready", 32'(acc), 32'd0);
        chk("flushed_valid", 32'(seen_v), 32'd0);
        exr = 1'b1;
        tick(acc); chk("run_after_flush", 32'(acc), 32'd1);
        v = 1'b0;
        tick(acc);

        step = "end";
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
